// File: rtl/simon_seq_engine.sv
// Round-based Simon sequence player/checker: shows symbols 0..r-1 of a latched
// pattern in round r, then checks the player's keys against them.
module simon_seq_engine #(
  parameter int unsigned NUM_SYM     = 9,
  parameter int unsigned SYM_W       = 2,
  parameter int unsigned SHOW_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES  = 12500000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_SYM*SYM_W-1:0] pattern,
  input  logic                     pattern_valid,
  input  logic                     key_valid,
  input  logic [SYM_W-1:0]         key_sym,
  output logic                     show_valid,
  output logic [SYM_W-1:0]         show_sym,
  output logic                     await_input,
  output logic                     busy,
  output logic [3:0]               round,
  output logic [3:0]               score,
  output logic                     win,
  output logic                     lose
);

  localparam int unsigned PAT_W   = NUM_SYM * SYM_W;
  localparam int unsigned MAX_CYC = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned CNT_W   = 4;

  localparam logic [TMR_W-1:0] SHOW_LAST = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_RND  = CNT_W'(NUM_SYM);
  localparam logic [SYM_W-1:0] BAD_KEY   = {SYM_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHOW,
    ST_GAP,
    ST_WAIT_IN,
    ST_WIN,
    ST_LOSE
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   round_q, round_d;
  logic [CNT_W-1:0]   score_q, score_d;
  logic [SYM_W-1:0]   cur_sym, nxt_sym;
  logic               idx_last;

  assign cur_sym  = pat_q[SYM_W*32'(idx_q) +: SYM_W];
  assign nxt_sym  = pat_d[SYM_W*32'(idx_d) +: SYM_W];
  assign idx_last = (idx_q == round_q - CNT_ONE);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    round_d = round_q;
    score_d = score_q;
    case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start && pattern_valid) begin
          pat_d   = pattern;
          round_d = CNT_ONE;
          idx_d   = '0;
          score_d = '0;
          timer_d = '0;
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (timer_q == SHOW_LAST) begin
          timer_d = '0;
          state_d = ST_GAP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          if (idx_last) begin
            idx_d   = '0;
            state_d = ST_WAIT_IN;
          end else begin
            idx_d   = idx_q + CNT_ONE;
            state_d = ST_SHOW;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_WAIT_IN: begin
        if (key_valid) begin
          // The all-ones key code never names a real symbol.
          if ((key_sym == BAD_KEY) || (key_sym != cur_sym)) begin
            state_d = ST_LOSE;
          end else if (!idx_last) begin
            idx_d = idx_q + CNT_ONE;
          end else begin
            score_d = score_q + CNT_ONE;
            if (round_q == LAST_RND) begin
              state_d = ST_WIN;
            end else begin
              round_d = round_q + CNT_ONE;
              idx_d   = '0;
              timer_d = '0;
              state_d = ST_SHOW;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State plus outputs decoded from the next state, so every output is a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pat_q       <= '0;
      timer_q     <= '0;
      idx_q       <= '0;
      round_q     <= '0;
      score_q     <= '0;
      show_valid  <= 1'b0;
      show_sym    <= '0;
      await_input <= 1'b0;
      busy        <= 1'b0;
      win         <= 1'b0;
      lose        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      round_q     <= round_d;
      score_q     <= score_d;
      show_valid  <= (state_d == ST_SHOW);
      show_sym    <= (state_d == ST_SHOW) ? nxt_sym : '0;
      await_input <= (state_d == ST_WAIT_IN);
      busy        <= (state_d == ST_SHOW) || (state_d == ST_GAP) || (state_d == ST_WAIT_IN);
      win         <= (state_d == ST_WIN);
      lose        <= (state_d == ST_LOSE);
    end
  end

  assign round = round_q;
  assign score = score_q;

endmodule

// File: tb/tb_simon_seq_engine.sv
// Directed bench for simon_seq_engine with SHOW_CYCLES=3, GAP_CYCLES=2 and the
// repeating 0,1,2 pattern; outputs are sampled 1 time unit after each rising edge.
module tb_simon_seq_engine;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [17:0] pattern;
  logic        pattern_valid;
  logic        key_valid;
  logic [1:0]  key_sym;
  logic        show_valid;
  logic [1:0]  show_sym;
  logic        await_input;
  logic        busy;
  logic [3:0]  round;
  logic [3:0]  score;
  logic        win;
  logic        lose;
  logic [14:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  simon_seq_engine #(
    .NUM_SYM(9), .SYM_W(2), .SHOW_CYCLES(3), .GAP_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .pattern_valid(pattern_valid), .key_valid(key_valid), .key_sym(key_sym),
    .show_valid(show_valid), .show_sym(show_sym), .await_input(await_input),
    .busy(busy), .round(round), .score(score), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  assign outs = {show_valid, show_sym, await_input, busy, round, score, win, lose};

  typedef struct {
    logic       st;
    logic       pv;
    logic       kv;
    logic [1:0] ks;
    logic       sv;
    logic [1:0] sym;
    logic       aw;
    logic       bz;
    logic [3:0] rnd;
    logic [3:0] scr;
    logic       w;
    logic       l;
  } vec_t;

  vec_t vecs [20];

  function automatic logic [14:0] pk(input logic sv, input logic [1:0] sym, input logic aw,
                                     input logic bz, input logic [3:0] rn, input logic [3:0] sc,
                                     input logic w, input logic l);
    return {sv, sym, aw, bz, rn, sc, w, l};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic st, input logic pv, input logic kv, input logic [1:0] ks);
    start = st; pattern_valid = pv; key_valid = kv; key_sym = ks;
    @(posedge clk); #1;
    start = 1'b0; key_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; key_valid = 1'b0; key_sym = 2'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Wait out the display of round r, then key it in; fail_last mistypes the final key.
  task automatic play_round(input int r, input bit fail_last);
    int n_show;
    logic [1:0] ks;
    n_show = show_valid ? 1 : 0;
    for (int c = 0; c < 200 && !await_input; c++) begin
      @(posedge clk); #1;
      if (show_valid) n_show++;
    end
    check($sformatf("await_r%0d", r), 32'(await_input), 32'd1);
    check($sformatf("show_cycles_r%0d", r), 32'(n_show), 32'(3 * r));
    for (int i = 0; i < r; i++) begin
      ks = 2'((fail_last && i == r - 1) ? (i + 1) % 3 : i % 3);
      step(F, T, T, ks);
      if (i < r - 1)
        check($sformatf("mid_key_r%0d_k%0d", r, i), 32'(outs), 32'(pk(F, 2'd0, T, T, 4'(r), 4'(r - 1), F, F)));
      else if (fail_last)
        check($sformatf("lose_r%0d", r), 32'(outs), 32'(pk(F, 2'd0, F, F, 4'(r), 4'(r - 1), F, T)));
      else if (r == 9)
        check("win_final", 32'(outs), 32'(pk(F, 2'd0, F, F, 4'd9, 4'd9, T, F)));
      else
        check($sformatf("next_round_r%0d", r), 32'(outs), 32'(pk(T, 2'd0, F, T, 4'(r + 1), 4'(r), F, F)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //        st pv kv ks     sv sym   aw bz rnd   scr   w  l
    vecs[0]  = '{T, T, F, 2'd0, T, 2'd0, F, T, 4'd1, 4'd0, F, F};
    vecs[1]  = '{F, T, F, 2'd0, T, 2'd0, F, T, 4'd1, 4'd0, F, F};
    vecs[2]  = '{F, T, F, 2'd0, T, 2'd0, F, T, 4'd1, 4'd0, F, F};
    vecs[3]  = '{F, T, F, 2'd0, F, 2'd0, F, T, 4'd1, 4'd0, F, F};
    vecs[4]  = '{F, T, F, 2'd0, F, 2'd0, F, T, 4'd1, 4'd0, F, F};
    vecs[5]  = '{F, T, F, 2'd0, F, 2'd0, T, T, 4'd1, 4'd0, F, F};
    vecs[6]  = '{F, T, T, 2'd0, T, 2'd0, F, T, 4'd2, 4'd1, F, F};
    vecs[7]  = '{F, T, T, 2'd1, T, 2'd0, F, T, 4'd2, 4'd1, F, F};
    vecs[8]  = '{F, T, F, 2'd0, T, 2'd0, F, T, 4'd2, 4'd1, F, F};
    vecs[9]  = '{F, T, F, 2'd0, F, 2'd0, F, T, 4'd2, 4'd1, F, F};
    vecs[10] = '{F, T, F, 2'd0, F, 2'd0, F, T, 4'd2, 4'd1, F, F};
    vecs[11] = '{F, T, F, 2'd0, T, 2'd1, F, T, 4'd2, 4'd1, F, F};
    vecs[12] = '{T, T, F, 2'd0, T, 2'd1, F, T, 4'd2, 4'd1, F, F};
    vecs[13] = '{F, T, F, 2'd0, T, 2'd1, F, T, 4'd2, 4'd1, F, F};
    vecs[14] = '{F, T, F, 2'd0, F, 2'd0, F, T, 4'd2, 4'd1, F, F};
    vecs[15] = '{F, T, F, 2'd0, F, 2'd0, F, T, 4'd2, 4'd1, F, F};
    vecs[16] = '{F, T, F, 2'd0, F, 2'd0, T, T, 4'd2, 4'd1, F, F};
    vecs[17] = '{F, T, T, 2'd0, F, 2'd0, T, T, 4'd2, 4'd1, F, F};
    vecs[18] = '{F, T, T, 2'd3, F, 2'd0, F, F, 4'd2, 4'd1, F, T};
    vecs[19] = '{F, T, T, 2'd0, F, 2'd0, F, F, 4'd2, 4'd1, F, T};

    pattern = 18'b10_01_00_10_01_00_10_01_00;
    pattern_valid = 1'b1;
    do_reset();
    check("reset_state", 32'(outs), 32'd0);

    // Round 1 and 2 display timing, ignored key/start while showing, key 3 loses.
    for (int i = 0; i < 20; i++) begin
      step(vecs[i].st, vecs[i].pv, vecs[i].kv, vecs[i].ks);
      check($sformatf("vec%0d", i), 32'(outs),
            32'(pk(vecs[i].sv, vecs[i].sym, vecs[i].aw, vecs[i].bz,
                   vecs[i].rnd, vecs[i].scr, vecs[i].w, vecs[i].l)));
    end

    // start without a valid pattern is ignored.
    do_reset();
    step(T, F, F, 2'd0);
    check("start_no_pv", 32'(outs), 32'd0);
    step(F, F, F, 2'd0);
    check("start_no_pv_hold", 32'(outs), 32'd0);

    // Full winning game; pattern changes after the latch must not matter.
    step(T, T, F, 2'd0);
    check("win_game_start", 32'(outs), 32'(pk(T, 2'd0, F, T, 4'd1, 4'd0, F, F)));
    pattern = 18'h3FFFF;
    for (int r = 1; r <= 9; r++) play_round(r, 1'b0);
    step(F, T, T, 2'd0);
    check("win_key_ignored", 32'(outs), 32'(pk(F, 2'd0, F, F, 4'd9, 4'd9, T, F)));
    step(F, T, F, 2'd0);
    check("win_hold", 32'(outs), 32'(pk(F, 2'd0, F, F, 4'd9, 4'd9, T, F)));

    // Restart from WIN, lose in round 3 with keys 0,1,0.
    pattern = 18'b10_01_00_10_01_00_10_01_00;
    step(T, T, F, 2'd0);
    check("restart_from_win", 32'(outs), 32'(pk(T, 2'd0, F, T, 4'd1, 4'd0, F, F)));
    play_round(1, 1'b0);
    play_round(2, 1'b0);
    play_round(3, 1'b1);
    step(F, T, F, 2'd0);
    check("lose_hold", 32'(outs), 32'(pk(F, 2'd0, F, F, 4'd3, 4'd2, F, T)));

    // Async reset in the middle of a GAP cycle clears outputs before the next edge.
    step(T, T, F, 2'd0);
    repeat (3) step(F, T, F, 2'd0);
    check("in_gap", 32'(outs), 32'(pk(F, 2'd0, F, T, 4'd1, 4'd0, F, F)));
    #2 reset = 1'b1;
    #1 check("async_reset", 32'(outs), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    step(T, T, F, 2'd0);
    check("restart_after_reset", 32'(outs), 32'(pk(T, 2'd0, F, T, 4'd1, 4'd0, F, F)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/simon_seq_engine.md
Name: simon_seq_engine

Overview:
Round-based sequence player/checker that consumes the 18-bit pattern from the random-pattern generator (9 symbols, 2 bits each, values 0..2). In round r it shows symbols 0..r-1 to the display/LED stage, then checks the player's key presses against the same symbols. It sits between the pattern generator and the display/score logic, and reports win, lose, current round and score.

Parameters:
NUM_SYM, 9, symbols in the pattern and the final round number
SYM_W, 2, bits per symbol
SHOW_CYCLES, 25000000, clock cycles each symbol is shown (must be >= 1)
GAP_CYCLES, 12500000, blank cycles after each shown symbol (must be >= 1)

Ports:
clk  in  1  system clock, all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse that begins a game
pattern  in  NUM_SYM*SYM_W  symbol k is at pattern[2k+1:2k]
pattern_valid  in  1  pattern is complete and stable (generator lock done)
key_valid  in  1  one-cycle pulse, player pressed a key
key_sym  in  SYM_W  symbol of the pressed key
show_valid  out  1  a symbol is currently being displayed
show_sym  out  SYM_W  symbol being displayed, 0 when show_valid=0
await_input  out  1  engine is accepting key presses
busy  out  1  game in progress (any state except IDLE/WIN/LOSE)
round  out  4  current round 1..NUM_SYM, 0 in IDLE
score  out  4  rounds completed in the current game
win  out  1  held high in WIN
lose  out  1  held high in LOSE

Behaviour:
- Reset (async, immediate, also mid-game): state=IDLE; all outputs 0; latched pattern, timer, index and round cleared.
- States: IDLE, SHOW, GAP, WAIT_IN, WIN, LOSE.
- start is accepted only in IDLE/WIN/LOSE and only with pattern_valid=1. On acceptance, on that edge: latch pattern; round=1, idx=0, score=0, win=lose=0, timer=0; next state SHOW. start with pattern_valid=0 is ignored. start while busy is ignored.
- SHOW: show_valid=1, show_sym=latched symbol idx. Stays exactly SHOW_CYCLES cycles, then goes to GAP with timer reset.
- GAP: show_valid=0, show_sym=0, for exactly GAP_CYCLES cycles. At the end, if idx==round-1: idx=0 and go to WAIT_IN. Otherwise idx+1 and go to SHOW.
- Timing: one show/gap pair takes SHOW_CYCLES+GAP_CYCLES cycles. Round r display takes r*(SHOW_CYCLES+GAP_CYCLES) cycles.
- key_valid outside WAIT_IN is ignored; it is never queued.
- WAIT_IN: await_input=1. On key_valid, compare key_sym with symbol idx.
  - Mismatch: go to LOSE. key_sym=3 is always a mismatch.
  - Match, idx<round-1: idx+1, stay in WAIT_IN.
  - Match, idx==round-1: score+1. If round==NUM_SYM go to WIN. Otherwise round+1, idx=0, timer=0, go to SHOW.
- No input timeout. WAIT_IN waits indefinitely.
- WIN/LOSE: win or lose held high; round and score frozen; busy=0. Exit only via an accepted start or reset.
- All outputs are registered. Each key's effect is visible one cycle after the key_valid edge.
- Changes on pattern after the latch have no effect until the next accepted start.
- Counters: timer width is the ceiling of log2(max(SHOW_CYCLES,GAP_CYCLES)+1); it saturates only via the state transitions above. round and score never exceed NUM_SYM.

Test Plan:
(All scenarios use SHOW_CYCLES=3, GAP_CYCLES=2, pattern=18'b10_01_00_10_01_00_10_01_00, i.e. symbols 0,1,2,0,1,2,0,1,2 for k=0..8.)
1. Reset, pattern_valid=1, start pulse → round=1 and show_valid=1, show_sym=0 for 3 cycles; then 2 blank cycles; then await_input=1.
2. Round 1 key 0 → score=1, round=2. Bench sees show_sym sequence 0 (3 cycles), gap, 1 (3 cycles), gap, then await_input.
3. Correct keys for all 9 rounds (round r: symbols 0..r-1) → win=1, score=9, round=9, busy=0. A later key_valid changes nothing.
4. Round 3, keys 0,1,0 → lose=1 one cycle after the third key; score=2, round=3. A key_valid pulse during SHOW has no effect. key_sym=3 in WAIT_IN → lose.
5. start with pattern_valid=0 → stays in IDLE, all outputs 0. start during SHOW → ignored, sequence unchanged.
6. Assert reset asynchronously mid-GAP (between clock edges) → all outputs 0 immediately. A subsequent valid start restarts at round=1, score=0.
